// File: rtl/alu_exec_unit.sv
// Handshaked RV32I ALU execute stage with registered result/zero/illegal outputs.
// Optional iterative RV32M MUL (low word) when ALU_EXEC_MUL_EN is defined.
module alu_exec_unit #(
    parameter int XLEN = 32,
    parameter int SHW  = $clog2(XLEN)
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [1:0]      alu_op,
    input  logic [2:0]      funct3,
    input  logic            funct7_5,
    input  logic            funct7_0,
    input  logic [XLEN-1:0] op_a,
    input  logic [XLEN-1:0] op_b,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] result,
    output logic            zero,
    output logic            illegal
);

`ifdef ALU_EXEC_MUL_EN
    localparam int CW = $clog2(XLEN + 1);
    typedef enum logic [1:0] {S_IDLE = 2'd0, S_MUL = 2'd1, S_HOLD = 2'd2} state_t;
`else
    typedef enum logic [1:0] {S_IDLE = 2'd0, S_HOLD = 2'd2} state_t;
`endif

    typedef enum logic [3:0] {
        OP_ADD, OP_SUB, OP_SLL, OP_SLT, OP_SLTU, OP_XOR,
        OP_SRL, OP_SRA, OP_OR, OP_AND, OP_MUL, OP_ILL
    } op_t;

    function automatic op_t decode(input logic [1:0] aop, input logic [2:0] f3,
                                   input logic f7_5, input logic f7_0);
        op_t op;
        op = OP_ILL;
        if (aop == 2'b00) begin
            op = OP_ADD;
        end else if (aop == 2'b01) begin
            op = OP_SUB;
        end else if (aop == 2'b10 && f7_0) begin
`ifdef ALU_EXEC_MUL_EN
            op = (f3 == 3'b000) ? OP_MUL : OP_ILL;
`else
            op = OP_ILL;
`endif
        end else begin
            // funct7_5 only selects SUB for register-register forms; ADDI ignores it
            case (f3)
                3'b000:  op = (f7_5 && aop == 2'b10) ? OP_SUB : OP_ADD;
                3'b001:  op = OP_SLL;
                3'b010:  op = OP_SLT;
                3'b011:  op = OP_SLTU;
                3'b100:  op = OP_XOR;
                3'b101:  op = f7_5 ? OP_SRA : OP_SRL;
                3'b110:  op = OP_OR;
                default: op = OP_AND;
            endcase
        end
        return op;
    endfunction

    function automatic logic [XLEN-1:0] alu_eval(input op_t op, input logic [XLEN-1:0] a,
                                                 input logic [XLEN-1:0] b);
        logic signed [XLEN-1:0] sa;
        logic signed [XLEN-1:0] sb;
        logic [SHW-1:0]         sh;
        logic [XLEN-1:0]        r;
        sa = a;
        sb = b;
        sh = b[SHW-1:0];
        case (op)
            OP_ADD:  r = a + b;
            OP_SUB:  r = a - b;
            OP_SLL:  r = a << sh;
            OP_SLT:  r = {{(XLEN-1){1'b0}}, (sa < sb)};
            OP_SLTU: r = {{(XLEN-1){1'b0}}, (a < b)};
            OP_XOR:  r = a ^ b;
            OP_SRL:  r = a >> sh;
            OP_SRA:  r = sa >>> sh;
            OP_OR:   r = a | b;
            OP_AND:  r = a & b;
            default: r = '0;
        endcase
        return r;
    endfunction

    state_t          state_q, state_d;
    logic [XLEN-1:0] result_q, result_d;
    logic            zero_q, zero_d;
    logic            illegal_q, illegal_d;
    op_t             op_dec;
    logic [XLEN-1:0] eval_res;
    logic            accept;

`ifdef ALU_EXEC_MUL_EN
    logic [XLEN-1:0] acc_q, acc_d;
    logic [XLEN-1:0] mcand_q, mcand_d;
    logic [XLEN-1:0] mplier_q, mplier_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [XLEN-1:0] acc_step;
`endif

    assign in_ready  = !reset && (state_q == S_IDLE || (state_q == S_HOLD && out_ready));
    assign accept    = in_valid && in_ready;
    assign op_dec    = decode(alu_op, funct3, funct7_5, funct7_0);
    assign eval_res  = alu_eval(op_dec, op_a, op_b);
    assign out_valid = (state_q == S_HOLD);
    assign result    = result_q;
    assign zero      = zero_q;
    assign illegal   = illegal_q;

    always_comb begin
        state_d   = state_q;
        result_d  = result_q;
        zero_d    = zero_q;
        illegal_d = illegal_q;
`ifdef ALU_EXEC_MUL_EN
        acc_d     = acc_q;
        mcand_d   = mcand_q;
        mplier_d  = mplier_q;
        cnt_d     = cnt_q;
        acc_step  = mplier_q[0] ? (acc_q + mcand_q) : acc_q;
`endif
        case (state_q)
`ifdef ALU_EXEC_MUL_EN
            S_MUL: begin
                // shift-add, one multiplier bit per cycle, LSB first; low word only
                acc_d    = acc_step;
                mcand_d  = mcand_q << 1;
                mplier_d = mplier_q >> 1;
                cnt_d    = cnt_q + 1'b1;
                if (cnt_q == CW'(XLEN - 1)) begin
                    state_d   = S_HOLD;
                    result_d  = acc_step;
                    zero_d    = (acc_step == '0);
                    illegal_d = 1'b0;
                end
            end
`endif
            default: begin
                if (accept) begin
`ifdef ALU_EXEC_MUL_EN
                    if (op_dec == OP_MUL) begin
                        state_d  = S_MUL;
                        acc_d    = '0;
                        mcand_d  = op_a;
                        mplier_d = op_b;
                        cnt_d    = '0;
                    end else begin
                        state_d   = S_HOLD;
                        result_d  = eval_res;
                        zero_d    = (eval_res == '0);
                        illegal_d = (op_dec == OP_ILL);
                    end
`else
                    state_d   = S_HOLD;
                    result_d  = eval_res;
                    zero_d    = (eval_res == '0);
                    illegal_d = (op_dec == OP_ILL);
`endif
                end else if (state_q == S_HOLD && out_ready) begin
                    state_d = S_IDLE;
                end
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= S_IDLE;
            result_q  <= '0;
            zero_q    <= 1'b0;
            illegal_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            result_q  <= result_d;
            zero_q    <= zero_d;
            illegal_q <= illegal_d;
        end
    end

`ifdef ALU_EXEC_MUL_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            acc_q    <= '0;
            mcand_q  <= '0;
            mplier_q <= '0;
            cnt_q    <= '0;
        end else begin
            acc_q    <= acc_d;
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
            cnt_q    <= cnt_d;
        end
    end
`endif

endmodule

// File: tb/tb_alu_exec_unit.sv
// Directed table-driven bench for alu_exec_unit plus hand sequences for
// backpressure, MUL latency (or MUL-as-illegal) and reset abort.
module tb_alu_exec_unit;
    localparam int XLEN = 32;

    logic            clk = 1'b0;
    logic            reset;
    logic            in_valid;
    logic            in_ready;
    logic [1:0]      alu_op;
    logic [2:0]      funct3;
    logic            funct7_5;
    logic            funct7_0;
    logic [XLEN-1:0] op_a;
    logic [XLEN-1:0] op_b;
    logic            out_valid;
    logic            out_ready;
    logic [XLEN-1:0] result;
    logic            zero;
    logic            illegal;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    alu_exec_unit #(.XLEN(XLEN)) dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
        .alu_op(alu_op), .funct3(funct3), .funct7_5(funct7_5), .funct7_0(funct7_0),
        .op_a(op_a), .op_b(op_b), .out_valid(out_valid), .out_ready(out_ready),
        .result(result), .zero(zero), .illegal(illegal)
    );

    typedef struct {
        logic [1:0]  aop;
        logic [2:0]  f3;
        logic        f75;
        logic        f70;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] exp_res;
        logic        exp_ill;
    } vec_t;

    vec_t tbl[15];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic drive(input logic v, input logic [1:0] aop, input logic [2:0] f3,
                         input logic f75, input logic f70,
                         input logic [31:0] a, input logic [31:0] b);
        in_valid = v;
        alu_op   = aop;
        funct3   = f3;
        funct7_5 = f75;
        funct7_0 = f70;
        op_a     = a;
        op_b     = b;
    endtask

    task automatic chk_out(input string name, input logic [31:0] exp_res, input logic exp_ill);
        chk({name, ".valid"}, {31'b0, out_valid}, 32'd1);
        chk({name, ".result"}, result, exp_res);
        chk({name, ".zero"}, {31'b0, zero}, {31'b0, (exp_res == 32'd0)});
        chk({name, ".illegal"}, {31'b0, illegal}, {31'b0, exp_ill});
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        bit seen;
        tbl[0]  = '{2'b00, 3'b000, 1'b0, 1'b0, 32'hFFFF_FFFF, 32'd1,        32'h0000_0000, 1'b0};
        tbl[1]  = '{2'b10, 3'b101, 1'b1, 1'b0, 32'h8000_0000, 32'd4,        32'hF800_0000, 1'b0};
        tbl[2]  = '{2'b10, 3'b101, 1'b0, 1'b0, 32'h8000_0000, 32'd4,        32'h0800_0000, 1'b0};
        tbl[3]  = '{2'b10, 3'b010, 1'b0, 1'b0, 32'h8000_0000, 32'd4,        32'h0000_0001, 1'b0};
        tbl[4]  = '{2'b10, 3'b011, 1'b0, 1'b0, 32'h8000_0000, 32'd4,        32'h0000_0000, 1'b0};
        tbl[5]  = '{2'b10, 3'b000, 1'b1, 1'b0, 32'd5,         32'd7,        32'hFFFF_FFFE, 1'b0};
        tbl[6]  = '{2'b11, 3'b000, 1'b1, 1'b0, 32'd5,         32'd7,        32'h0000_000C, 1'b0};
        tbl[7]  = '{2'b10, 3'b001, 1'b0, 1'b0, 32'd1,         32'h0000_003F, 32'h8000_0000, 1'b0};
        tbl[8]  = '{2'b10, 3'b100, 1'b0, 1'b0, 32'hF0F0_F0F0, 32'hFF00_FF00, 32'h0FF0_0FF0, 1'b0};
        tbl[9]  = '{2'b10, 3'b110, 1'b0, 1'b0, 32'hF0F0_F0F0, 32'h0F0F_0000, 32'hFFFF_F0F0, 1'b0};
        tbl[10] = '{2'b10, 3'b111, 1'b0, 1'b0, 32'hF0F0_F0F0, 32'hFF00_FF00, 32'hF000_F000, 1'b0};
        tbl[11] = '{2'b01, 3'b000, 1'b0, 1'b0, 32'd3,         32'd3,        32'h0000_0000, 1'b0};
        tbl[12] = '{2'b10, 3'b100, 1'b0, 1'b1, 32'h1234_5678, 32'h9ABC_DEF0, 32'h0000_0000, 1'b1};
        tbl[13] = '{2'b11, 3'b101, 1'b0, 1'b0, 32'hFFFF_FFFF, 32'd31,       32'h0000_0001, 1'b0};
        tbl[14] = '{2'b11, 3'b000, 1'b0, 1'b1, 32'd2,         32'd3,        32'h0000_0005, 1'b0};

        reset     = 1'b1;
        out_ready = 1'b1;
        drive(1'b0, 2'b00, 3'b000, 1'b0, 1'b0, 32'd0, 32'd0);
        repeat (3) @(negedge clk);
        chk("rst.out_valid", {31'b0, out_valid}, 32'd0);
        chk("rst.result", result, 32'd0);
        chk("rst.zero", {31'b0, zero}, 32'd0);
        chk("rst.illegal", {31'b0, illegal}, 32'd0);
        chk("rst.in_ready", {31'b0, in_ready}, 32'd0);
        reset = 1'b0;

        // back-to-back stream, in_ready must stay high
        for (int i = 0; i < 15; i++) begin
            @(negedge clk);
            if (i > 0) chk_out($sformatf("vec%0d", i - 1), tbl[i-1].exp_res, tbl[i-1].exp_ill);
            chk($sformatf("vec%0d.in_ready", i), {31'b0, in_ready}, 32'd1);
            drive(1'b1, tbl[i].aop, tbl[i].f3, tbl[i].f75, tbl[i].f70, tbl[i].a, tbl[i].b);
        end
        @(negedge clk);
        chk_out("vec14", tbl[14].exp_res, tbl[14].exp_ill);
        drive(1'b0, 2'b00, 3'b000, 1'b0, 1'b0, 32'd0, 32'd0);
        @(negedge clk);
        chk("drain.out_valid", {31'b0, out_valid}, 32'd0);

        // backpressure: SUB 5-7 held while out_ready low; competing request ignored
        out_ready = 1'b0;
        drive(1'b1, 2'b01, 3'b000, 1'b0, 1'b0, 32'd5, 32'd7);
        @(negedge clk);
        drive(1'b1, 2'b00, 3'b000, 1'b0, 1'b0, 32'd1, 32'd1);
        for (int k = 0; k < 4; k++) begin
            chk_out($sformatf("bp%0d", k), 32'hFFFF_FFFE, 1'b0);
            chk($sformatf("bp%0d.in_ready", k), {31'b0, in_ready}, 32'd0);
            @(negedge clk);
        end
        out_ready = 1'b1;
        #1;
        chk("bp.release.in_ready", {31'b0, in_ready}, 32'd1);
        @(negedge clk);
        drive(1'b0, 2'b00, 3'b000, 1'b0, 1'b0, 32'd0, 32'd0);
        chk_out("bp.next", 32'd2, 1'b0);
        @(negedge clk);

`ifdef ALU_EXEC_MUL_EN
        // MUL latency: out_valid first seen XLEN+1 cycles after acceptance
        drive(1'b1, 2'b10, 3'b000, 1'b0, 1'b1, 32'h0001_0003, 32'h0002_0005);
        @(negedge clk);
        drive(1'b0, 2'b00, 3'b000, 1'b0, 1'b0, 32'd0, 32'd0);
        seen = 1'b0;
        for (int n = 1; n <= 40 && !seen; n++) begin
            if (out_valid) begin
                seen = 1'b1;
                chk("mul.latency", n, XLEN + 1);
                chk_out("mul", 32'h000B_000F, 1'b0);
            end else if (in_ready) begin
                chk($sformatf("mul.busy%0d.in_ready", n), {31'b0, in_ready}, 32'd0);
            end
            if (!seen) @(negedge clk);
        end
        if (!seen) chk("mul.timeout", 32'd0, 32'd1);
        @(negedge clk);

        // reset 10 cycles into a MUL aborts it
        drive(1'b1, 2'b10, 3'b000, 1'b0, 1'b1, 32'd7, 32'd9);
        @(negedge clk);
        drive(1'b0, 2'b00, 3'b000, 1'b0, 1'b0, 32'd0, 32'd0);
        repeat (10) @(negedge clk);
        reset = 1'b1;
        #1;
        chk("rstmul.out_valid", {31'b0, out_valid}, 32'd0);
        chk("rstmul.in_ready", {31'b0, in_ready}, 32'd0);
        chk("rstmul.result", result, 32'd0);
        @(negedge clk);
        reset = 1'b0;
        seen = 1'b0;
        for (int n = 0; n < 40; n++) begin
            @(negedge clk);
            if (out_valid) seen = 1'b1;
        end
        chk("rstmul.no_result", {31'b0, seen}, 32'd0);
        chk("rstmul.idle_ready", {31'b0, in_ready}, 32'd1);
`else
        // without the multiplier, MUL decodes as a 1-cycle illegal op
        drive(1'b1, 2'b10, 3'b000, 1'b0, 1'b1, 32'h0001_0003, 32'h0002_0005);
        @(negedge clk);
        drive(1'b0, 2'b00, 3'b000, 1'b0, 1'b0, 32'd0, 32'd0);
        chk_out("mul_ill", 32'd0, 1'b1);
        @(negedge clk);

        // reset while a result is held discards it
        out_ready = 1'b0;
        drive(1'b1, 2'b00, 3'b000, 1'b0, 1'b0, 32'd40, 32'd2);
        @(negedge clk);
        drive(1'b0, 2'b00, 3'b000, 1'b0, 1'b0, 32'd0, 32'd0);
        chk_out("hold", 32'd42, 1'b0);
        repeat (3) @(negedge clk);
        reset = 1'b1;
        #1;
        chk("rsthold.out_valid", {31'b0, out_valid}, 32'd0);
        chk("rsthold.result", result, 32'd0);
        chk("rsthold.in_ready", {31'b0, in_ready}, 32'd0);
        @(negedge clk);
        reset = 1'b0;
        out_ready = 1'b1;
        seen = 1'b0;
        for (int n = 0; n < 10; n++) begin
            @(negedge clk);
            if (out_valid) seen = 1'b1;
        end
        chk("rsthold.no_result", {31'b0, seen}, 32'd0);
        chk("rsthold.idle_ready", {31'b0, in_ready}, 32'd1);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule

// File: doc/alu_exec_unit.md
# alu_exec_unit

Parametrised, handshaked ALU execute stage for the RISC core. It replaces the separate "ALU op decode plus combinational ALU" pair with one block that takes the raw control fields (`alu_op`, `funct3`, `funct7` bits) and operands. It decodes the full RV32I integer ALU set and registers the result behind a valid/ready handshake. An optional iterative multiplier covers the RV32M MUL (low-word) op.

## Interface
Parameters:
- `XLEN`, default 32: operand and result width. Must be ≥ 8 and a power of 2.
- `SHW`, default `$clog2(XLEN)`: shift-amount width. Derived; not overridden.

Ports:
- `clk`  in  1  single clock; all state updates on the rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `in_valid`  in  1  request valid.
- `in_ready`  out  1  block can accept a request this cycle.
- `alu_op`  in  2  00 = ADD (load/store address), 01 = SUB (branch compare), 10 = R-type, 11 = I-type ALU.
- `funct3`  in  3  instruction `funct3`.
- `funct7_5`  in  1  instruction bit 30.
- `funct7_0`  in  1  instruction bit 25 (M-extension select).
- `op_a`, `op_b`  in  XLEN  operands.
- `out_valid`  out  1  result valid.
- `out_ready`  in  1  consumer takes the result.
- `result`  out  XLEN  registered result.
- `zero`  out  1  result equals 0.
- `illegal`  out  1  request decoded to an unsupported op; `result` is 0.

## Operation
- A request is accepted on a cycle with `in_valid && in_ready`. All inputs are sampled only at acceptance.
- `in_ready = !reset && (state==IDLE || (state==HOLD && out_ready))`. This allows back-to-back single-cycle ops.
- Decode:
  - `alu_op` 00 → ADD; 01 → SUB.
  - `alu_op` 10/11, by `funct3`:
    - 000: ADD; SUB if `funct7_5` and `alu_op` = 10.
    - 001: SLL.
    - 010: SLT (signed).
    - 011: SLTU.
    - 100: XOR.
    - 101: SRL, or SRA if `funct7_5`.
    - 110: OR.
    - 111: AND.
  - `alu_op` 10 with `funct7_0` = 1 and `funct3` = 000 → MUL. Any other `funct3` with `funct7_0` = 1 → illegal.
- Shift amount is `op_b[SHW-1:0]`. SRA sign-fills from `op_a[XLEN-1]`.
- SLT and SLTU produce the value 1 or 0, zero-extended to XLEN.
- ADD, SUB and MUL wrap modulo 2^XLEN. No carry or overflow output.
- States:
  - IDLE: waiting for a request.
  - MUL: iterative multiply in progress.
  - HOLD: result presented.
- Transitions:
  - IDLE, or HOLD with `out_ready`, on acceptance: MUL op → MUL; any other op (including illegal) → HOLD with the result registered.
  - HOLD with `out_ready` and no new acceptance → IDLE.
  - MUL → HOLD after XLEN iterations.
- MUL datapath: shift-add, one multiplier bit per cycle, LSB first. Accumulator and multiplicand shift are XLEN wide, so only the low word is kept. Counter is `$clog2(XLEN+1)` bits.
- `zero` and `illegal` are registered with `result` and are valid only while `out_valid` = 1.
- In HOLD, `result`, `zero` and `illegal` stay stable until `out_ready`.

## Timing
- Reset state: IDLE. Outputs: `out_valid` = 0, `result` = 0, `zero` = 0, `illegal` = 0, `in_ready` = 0 while `reset` is high.
- Single-cycle ops and illegal ops: `out_valid` rises 1 cycle after acceptance.
- MUL: `out_valid` rises XLEN+1 cycles after acceptance (33 for XLEN = 32). `in_ready` is 0 throughout MUL.
- Throughput: one single-cycle op per clock when `out_ready` is held at 1.
- Reset mid-MUL or mid-HOLD: the operation is aborted, the result is discarded, and the block returns to IDLE with outputs at their reset values.
- `in_valid` while `in_ready` = 0: ignored, no side effects.

## Configuration
- `ALU_EXEC_MUL_EN` defined: MUL decode, the MUL state, counter and shift-add datapath are compiled in.
- `ALU_EXEC_MUL_EN` undefined: MUL datapath, state and counter are absent. Any `alu_op` = 10 request with `funct7_0` = 1 is illegal: 1-cycle latency, `illegal` = 1, `result` = 0.

## Test plan
- Reset, then ADD: `alu_op` = 00, `op_a` = 0xFFFF_FFFF, `op_b` = 1, `out_ready` = 1. Expect `out_valid` 1 cycle later, `result` = 0, `zero` = 1.
- R-type ops, one per cycle with `op_a` = 0x8000_0000, `op_b` = 4, `out_ready` = 1:
  - SRA → 0xF800_0000; SRL → 0x0800_0000; SLT → 1; SLTU → 0.
  - Check in_ready is never deasserted across the stream.
- MUL (macro defined): `op_a` = 0x0001_0003, `op_b` = 0x0002_0005. Expect `result` = 0x000B_000F after exactly 33 cycles, with `in_ready` = 0 in between.
- Backpressure: SUB 5 − 7 with `out_ready` = 0 for 4 cycles. Expect `result` = 0xFFFF_FFFE held stable, `in_ready` = 0; the next request is accepted in the same cycle `out_ready` rises.
- Illegal: `alu_op` = 10, `funct7_0` = 1, `funct3` = 100. Expect `illegal` = 1, `result` = 0 after 1 cycle. Also, without the macro, MUL → illegal.
- Assert `reset` 10 cycles into a MUL. Expect an immediate return to IDLE, `out_valid` = 0, and no result produced after reset release.
